// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage front end. A PC register addresses a combinational instruction
// memory. Each accepted fetch writes {pc, inst} into a small FIFO and advances
// the PC by 4. Decode drains the FIFO head through a valid/ready handshake.
// A taken redirect flushes the FIFO and reloads the PC in the same cycle.
//
// Parameters
//   RESET_PC   PC value loaded while reset is asserted
//   BUF_DEPTH  fetch buffer entries (2 or 4)
//
// Ports
//   clk              single clock, all state on the rising edge
//   rst              asynchronous active-low reset
//   imem_addr        byte address to instruction memory (the PC register)
//   imem_inst        instruction word for imem_addr, same cycle
//   redirect_valid   branch/jump taken this cycle
//   redirect_target  new PC when redirect_valid is high
//   out_valid        buffer head valid for decode
//   out_ready        decode accepts the head this cycle
//   out_inst         instruction at buffer head (0 when empty)
//   out_pc           PC of instruction at buffer head (0 when empty)
//   misalign_err     sticky misaligned-redirect flag
//
// Optional feature
//   IFETCH_ALIGN_CHECK_EN  when defined, redirects whose target is not word
//                          aligned are ignored and set misalign_err until
//                          reset. When undefined, the target's low two bits
//                          are dropped and misalign_err is tied to 0.
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        misalign_err
);

  // Only depths 2 and 4 are supported, so the pointer is one or two bits.
  localparam int PTR_W = (BUF_DEPTH > 2) ? 2 : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t           r_buf [BUF_DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_pc;

  logic             w_redirect;   // redirect that is actually taken
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [31:0]      w_target;
  logic [CNT_W-1:0] w_count_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Redirect qualification
  // ---------------------------------------------------------------------------
`ifdef IFETCH_ALIGN_CHECK_EN
  logic w_target_aligned;
  logic r_misalign;

  assign w_target_aligned = (redirect_target[1:0] == 2'b00);
  assign w_redirect       = redirect_valid & w_target_aligned;
  assign w_target         = redirect_target;
  assign misalign_err     = r_misalign;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_misalign <= 1'b0;
    end else if (redirect_valid && !w_target_aligned) begin
      r_misalign <= 1'b1;
    end
  end
`else
  logic w_unused_target_lsb;

  assign w_redirect          = redirect_valid;
  assign w_target            = {redirect_target[31:2], 2'b00};
  assign misalign_err        = 1'b0;
  assign w_unused_target_lsb = ^redirect_target[1:0];
`endif

  // ---------------------------------------------------------------------------
  // Handshake and FIFO control
  // ---------------------------------------------------------------------------
  assign w_full    = (r_count == FULL_CNT);
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready;
  // A pop frees the slot the push lands in, so a full FIFO can still fetch.
  assign w_push    = ~w_redirect & (~w_full | w_pop);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_count_nxt = r_count;
    if (w_redirect) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_ONE;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CNT_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_redirect) begin
        r_pc   <= w_target;
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_push) begin
          r_pc   <= r_pc + 32'd4;
          r_tail <= ptr_inc(r_tail);
        end
        if (w_pop) begin
          r_head <= ptr_inc(r_head);
        end
      end
    end
  end

  // NOTE: the storage array has no reset; validity comes solely from r_count,
  // and the outputs are masked to zero while the buffer is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf[r_tail] <= '{pc: r_pc, inst: imem_inst};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_addr = r_pc;
  assign out_pc    = out_valid ? r_buf[r_head].pc   : 32'h0;
  assign out_inst  = out_valid ? r_buf[r_head].inst : 32'h0;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000: PC loaded on reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2: fetch buffer entries; legal values 2 or 4.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port imem_addr, output, 32 bits: byte address to instruction memory, equal to PC register.
REQ-006 SHALL have port imem_inst, input, 32 bits: instruction word returned combinationally for imem_addr in the same cycle.
REQ-007 SHALL have port redirect_valid, input, 1 bit: branch/jump taken this cycle.
REQ-008 SHALL have port redirect_target, input, 32 bits: new PC when redirect_valid=1.
REQ-009 SHALL have port out_valid, output, 1 bit: buffer head valid for decode.
REQ-010 SHALL have port out_ready, input, 1 bit: decode accepts head this cycle.
REQ-011 SHALL have port out_inst, output, 32 bits: instruction at buffer head.
REQ-012 SHALL have port out_pc, output, 32 bits: PC of instruction at buffer head.
REQ-013 SHALL have port misalign_err, output, 1 bit: sticky misaligned-redirect flag (see Configuration).

Function
REQ-014 SHALL hold a PC register and a FIFO of BUF_DEPTH entries, each {pc, inst}.
REQ-015 SHALL define pop = out_valid & out_ready; push = ~redirect_valid & (~full | pop).
REQ-016 On push, SHALL write {PC, imem_inst} at FIFO tail and set PC <= PC + 4 (mod 2^32; 32'hFFFFFFFC wraps to 0).
REQ-017 When no push and no redirect, PC SHALL hold.
REQ-018 out_valid SHALL be 1 iff count > 0; out_inst/out_pc SHALL show head entry, 0 when empty.
REQ-019 Push into an empty FIFO SHALL make out_valid 1 the next cycle (1-cycle fetch-to-decode latency); no same-cycle bypass.
REQ-020 Simultaneous push and pop SHALL keep count unchanged, including when full.
REQ-021 Pop SHALL advance head; pop with count=0 SHALL be impossible since out_valid=0.
REQ-022 redirect_valid=1 SHALL take priority: flush all entries (count <= 0, out_valid=0 next cycle), suppress push, set PC <= redirect_target; concurrent pop is discarded with flush.
REQ-023 Redirect during back-to-back redirects SHALL use the latest target each cycle.
REQ-024 FIFO pointers SHALL wrap modulo BUF_DEPTH.

Reset
REQ-025 While rst=0: PC=RESET_PC, count=0, pointers=0, out_valid=0, out_inst=0, out_pc=0, misalign_err=0, imem_addr=RESET_PC.
REQ-026 Reset assertion mid-operation SHALL discard all buffered entries immediately; first push occurs on the first rising edge after rst deasserts.

Configuration
REQ-027 Macro IFETCH_ALIGN_CHECK_EN SHALL control redirect alignment checking.
REQ-028 With IFETCH_ALIGN_CHECK_EN defined: redirect with redirect_target[1:0]!=0 SHALL be ignored (no flush, PC unchanged, normal push/pop) and set misalign_err=1 until reset.
REQ-029 Without IFETCH_ALIGN_CHECK_EN: PC <= {redirect_target[31:2],2'b00} on every redirect; misalign_err tied 0.

Verification
REQ-030 Reset release, out_ready=1, memory word at addr N = 32'h1000_0000+N -> imem_addr 0,4,8,... one per cycle; out_pc=0/out_inst=32'h10000000 one cycle after first push, then consecutive.
REQ-031 out_ready=0 for 5 cycles from reset -> FIFO fills to BUF_DEPTH=2 (pc 0,4), PC holds at 8; release -> pc 0,4,8 delivered in order with no gaps.
REQ-032 Full FIFO with out_ready=1 -> simultaneous push/pop every cycle, count stays 2, no dropped or duplicated PCs.
REQ-033 redirect_valid=1, target 32'h00000014, FIFO holding pc 8,12 -> next cycle out_valid=0, imem_addr=20; following cycle out_pc=20.
REQ-034 RESET_PC=32'hFFFFFFF8 -> fetched PCs FFFFFFF8, FFFFFFFC, 00000000.
REQ-035 With IFETCH_ALIGN_CHECK_EN: redirect target 32'h00000016 -> misalign_err=1, stream continues unbroken; without it: PC becomes 32'h00000014.
